// File: rtl/craps_turn_sched.sv
// craps_turn_sched: round-robin craps table controller.
// Shares one 8-bit LFSR dice roller among NPLAYERS players. It sequences
// the come-out roll and the point rolls, emits one-cycle win/lose pulses
// and keeps a saturating win score for each player.
// Optional feature: define CRAPS_TURN_TIMEOUT_EN to forfeit a turn after
// TIMEOUT idle cycles in IDLE or POINT.
module craps_turn_sched #(
  parameter int          NPLAYERS = 4,
  parameter int          SCORE_W  = 8,
  parameter logic [7:0]  SEED     = 8'hA1,
  parameter int          TIMEOUT  = 1000,
  localparam int         PW       = $clog2(NPLAYERS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NPLAYERS-1:0]          rb,
  input  logic                         seed_ld,
  input  logic [7:0]                   seed,
  output logic [PW-1:0]                turn,
  output logic [2:0]                   die_a,
  output logic [2:0]                   die_b,
  output logic [3:0]                   sum,
  output logic [3:0]                   point,
  output logic                         point_valid,
  output logic                         win_pulse,
  output logic                         lose_pulse,
  output logic                         busy,
  output logic [NPLAYERS*SCORE_W-1:0]  scores
);

  typedef enum logic [2:0] {
    S_IDLE, S_ROLL, S_EVAL, S_POINT, S_PROLL, S_PEVAL, S_RESULT
  } state_t;

  localparam logic [PW-1:0] LAST_PLAYER = PW'(NPLAYERS - 1);

  state_t               state, next_state;
  logic [7:0]           lfsr;
  logic [NPLAYERS-1:0]  rb_q;
  logic                 press, rel;
  logic                 capture;
  logic                 res_win;
  logic                 timeout_hit;
  logic [2:0]           roll_a, roll_b;
  logic                 come_win, come_lose;
  logic [SCORE_W-1:0]   score_q [NPLAYERS];

  // Map a raw 3-bit LFSR field onto a die face: (v % 6) + 1.
  function automatic logic [2:0] roll_die(input logic [2:0] v);
    case (v)
      3'd0:    return 3'd1;
      3'd1:    return 3'd2;
      3'd2:    return 3'd3;
      3'd3:    return 3'd4;
      3'd4:    return 3'd5;
      3'd5:    return 3'd6;
      3'd6:    return 3'd1;
      default: return 3'd2;
    endcase
  endfunction

  assign roll_a    = roll_die(lfsr[2:0]);
  assign roll_b    = roll_die(lfsr[5:3]);
  assign press     = rb[turn] & ~rb_q[turn];
  assign rel       = ~rb[turn] & rb_q[turn];
  assign come_win  = (sum == 4'd7) || (sum == 4'd11);
  assign come_lose = (sum == 4'd2) || (sum == 4'd3) || (sum == 4'd12);
  assign busy      = (state != S_IDLE);

  // Free-running dice source; a seed load overrides the shift, and an
  // all-zero seed (the LFSR lock-up value) is replaced by SEED.
  // NOTE: reset is synchronous and active-high, so rst is tested inside the
  // clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst)
      lfsr <= SEED;
    else if (seed_ld)
      lfsr <= (seed == 8'h00) ? SEED : seed;
    else
      // NOTE: all state updates use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Previous button levels for press/release edge detection.
  always_ff @(posedge clk) begin
    if (rst) rb_q <= '0;
    else     rb_q <= rb;
  end

`ifdef CRAPS_TURN_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] idle_cnt;

  // Idle counter: runs only while waiting for a press, clears on any move.
  always_ff @(posedge clk) begin
    if (rst || (state != next_state) || !((state == S_IDLE) || (state == S_POINT)))
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + TW'(1);
  end

  assign timeout_hit = ((state == S_IDLE) || (state == S_POINT)) &&
                       (idle_cnt == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic and capture strobe.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -> no latches.
    next_state = state;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (press)            next_state = S_ROLL;
        else if (timeout_hit) next_state = S_RESULT;
      end
      S_ROLL: begin
        if (rel) begin
          capture    = 1'b1;
          next_state = S_EVAL;
        end
      end
      S_EVAL: begin
        if (come_win || come_lose) next_state = S_RESULT;
        else                       next_state = S_POINT;
      end
      S_POINT: begin
        if (press)            next_state = S_PROLL;
        else if (timeout_hit) next_state = S_RESULT;
      end
      S_PROLL: begin
        if (rel) begin
          capture    = 1'b1;
          next_state = S_PEVAL;
        end
      end
      S_PEVAL: begin
        if ((sum == point) || (sum == 4'd7)) next_state = S_RESULT;
        else                                 next_state = S_POINT;
      end
      S_RESULT: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Dice capture, point bookkeeping, result pulses, scores and turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      die_a       <= '0;
      die_b       <= '0;
      sum         <= '0;
      point       <= '0;
      point_valid <= 1'b0;
      win_pulse   <= 1'b0;
      lose_pulse  <= 1'b0;
      res_win     <= 1'b0;
      turn        <= '0;
      // NOTE: the score array is a handful of flops that must read zero
      // after reset, so it is cleared here rather than left as a RAM.
      for (int i = 0; i < NPLAYERS; i++) score_q[i] <= '0;
    end else begin
      win_pulse  <= 1'b0;
      lose_pulse <= 1'b0;
      if (capture) begin
        die_a <= roll_a;
        die_b <= roll_b;
        sum   <= {1'b0, roll_a} + {1'b0, roll_b};
      end
      case (state)
        S_EVAL: begin
          if (come_win)       res_win <= 1'b1;
          else if (come_lose) res_win <= 1'b0;
          else begin
            point       <= sum;
            point_valid <= 1'b1;
          end
        end
        S_PEVAL: res_win <= (sum == point);
        S_IDLE, S_POINT: begin
          if (next_state == S_RESULT) res_win <= 1'b0;
        end
        S_RESULT: begin
          win_pulse   <= res_win;
          lose_pulse  <= ~res_win;
          point_valid <= 1'b0;
          if (res_win && (score_q[turn] != {SCORE_W{1'b1}}))
            score_q[turn] <= score_q[turn] + SCORE_W'(1);
          turn <= (turn == LAST_PLAYER) ? '0 : turn + PW'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NPLAYERS; i++) begin : g_scores
    assign scores[i*SCORE_W +: SCORE_W] = score_q[i];
  end

endmodule
